// File: rtl/mem_bus_ctrl.sv
// Data-memory bus controller: one strobe/acknowledge word transfer per request,
// with misalignment and no-acknowledge timeout reported through err.
module mem_bus_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_as,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_dout,
  input  logic [31:0] bus_din,
  input  logic        bus_ack
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             aligned;
  logic             timeout;

  assign aligned = (addr[1:0] == 2'b00);
  assign timeout = !bus_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = aligned ? ACCESS : DONE;
        end
      end
      ACCESS: begin
        if (bus_ack || timeout) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status outputs are registered copies of the next state; datapath latches
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      bus_as   <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      bus_wr   <= 1'b0;
      bus_addr <= '0;
      bus_dout <= '0;
      wait_cnt <= '0;
    end else begin
      busy   <= (state_nxt != IDLE);
      done   <= (state_nxt == DONE);
      bus_as <= (state_nxt == ACCESS);
      case (state)
        IDLE: begin
          if (req) begin
            if (aligned) begin
              bus_wr   <= we;
              bus_addr <= {addr[31:2], 2'b00};
              bus_dout <= wdata;
              err      <= 1'b0;
              wait_cnt <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (bus_ack) begin
            if (!bus_wr) begin
              rdata <= bus_din;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            if (timeout) begin
              err <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Data-memory bus controller for the DLX load/store path, sitting directly downstream of the MMU. It accepts a single-word read or write request carrying the MMU's 32-bit physical address and runs one strobe/acknowledge cycle on the external memory bus. It returns read data, a one-cycle completion pulse and an error flag. Misaligned accesses and transactions with no acknowledge within a bounded time are reported as errors.

## Interface
Parameters:
- TIMEOUT, default 15: maximum number of cycles bus_as stays high without bus_ack before the transaction aborts; legal range 1..255.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- req  in  1  transaction request from the CPU memory stage; sampled only in IDLE
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  32  physical address from the MMU; sampled with req
- wdata  in  32  write data; sampled with req
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  error status of the last completed transaction
- rdata  out  32  read data of the last successful read
- bus_as  out  1  address strobe to memory
- bus_wr  out  1  write qualifier; valid while bus_as=1
- bus_addr  out  32  word address; valid while bus_as=1
- bus_dout  out  32  write data; valid while bus_as=1
- bus_din  in  32  read data from memory; valid when bus_ack=1
- bus_ack  in  1  memory acknowledge; honoured only while bus_as=1

## Operation
- FSM states: IDLE, ACCESS, DONE. All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- IDLE, req=1, addr[1:0]==0:
  - latch we, addr, wdata
  - clear err and the wait counter
  - go to ACCESS
- IDLE, req=1, addr[1:0]!=0:
  - no bus cycle is started
  - set err=1, go to DONE
- ACCESS:
  - bus_as=1, bus_wr=latched we
  - bus_addr = {latched addr[31:2], 2'b00}
  - bus_dout = latched wdata
  - wait counter increments each cycle that bus_ack is 0 at the edge
- ACCESS, bus_ack=1 at an edge:
  - on a read, rdata <= bus_din
  - err stays 0, go to DONE
- ACCESS, bus_ack=0 and counter == TIMEOUT-1 at an edge:
  - set err=1, go to DONE
  - rdata is unchanged
- DONE:
  - done=1, bus_as=0
  - unconditionally return to IDLE
  - req is ignored in DONE
- err holds its value until the next request is accepted.
- rdata changes only on a successful read.
- Counter width is 8 bits and never wraps, because the counter is cleared on every accept.
- Reset values:
  - state=IDLE
  - busy=0, done=0, err=0, rdata=0
  - bus_as=0, bus_wr=0, bus_addr=0, bus_dout=0
  - counter=0
- Reset asserted mid-transaction abandons the transaction: bus_as drops on the next edge, and no done pulse or rdata update is produced.

## Timing
- Best case, read or write, with req sampled at edge 0:
  - bus_as=1 during cycle 1
  - bus_ack=1 sampled at edge 1
  - done=1 during cycle 2
  - IDLE in cycle 3; the next req can be accepted at edge 3
  - request-to-done latency is 2 cycles; throughput is one transaction per 3 cycles
- Wait states: each cycle bus_ack=0 adds one cycle. bus_as stays high for at most TIMEOUT cycles.
- Timeout: the abort occurs at the TIMEOUT-th edge with bus_as=1 and bus_ack=0. done rises in the following cycle.
- bus_ack=1 on the same edge the timeout would fire counts as success: err=0.
- Misaligned request: done=1 and err=1 in the cycle after acceptance; bus_as never rises.
- bus_ack while bus_as=0 is ignored.
- req held high continuously is treated as back-to-back requests, accepted in every IDLE cycle. In the best case that is every 3rd cycle.

## Test plan
- Reset then idle: reset=1 for 2 cycles with req=0. Required: all outputs 0 and busy=0.
- Aligned read, addr=0x0000_1234→0x0000_1234, we=0, bus_ack=1 in the first ACCESS cycle, bus_din=0xDEAD_BEEF:
  - bus_as high for exactly 1 cycle, bus_addr=0x0000_1234, bus_wr=0
  - done pulses 2 cycles after req, rdata=0xDEAD_BEEF, err=0
- Write with 3 wait states, addr=0x0000_0100, wdata=0xA5A5_0F0F, ack at the 4th ACCESS edge:
  - bus_as high for 4 cycles, bus_wr=1, bus_dout=0xA5A5_0F0F
  - done pulses, err=0, rdata unchanged
- Timeout, TIMEOUT=15, read with bus_ack held 0:
  - bus_as high for exactly 15 cycles, then done=1 and err=1, rdata unchanged
  - repeat with ack arriving on the 15th edge: err=0 and rdata updated
- Misaligned request, addr=0x0000_0102: done=1 and err=1 on the next cycle; bus_as stays 0 throughout.
- Reset mid-ACCESS, followed by a fresh read:
  - reset during the 2nd wait cycle: bus_as=0 and state IDLE after the edge, no done pulse
  - the following read completes normally
